// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - instruction-decode / datapath-control bundle for mc_ctrl
// Ports (signals):
//   op, funct        IR opcode and function fields into the controller
//   alu_zero         ALU zero flag, dm_ready data memory ready
//   pc_wr, npc_sel   PC write enable and next-PC select
//   ir_wr, reg_wr    IR / register-file write enables
//   reg_dst, wd_sel  register destination and write-data selects
//   alu_src, alu_op  ALU operand-B select and operation
//   ext_op, mem_wr   immediate extender mode and data memory write enable
//   state, instr_cnt debug state and retired-instruction count
//   illegal          unsupported-instruction pulse
// Modports: master = control unit, slave = datapath side.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             dm_ready;
  logic             pc_wr;
  logic [1:0]       npc_sel;
  logic             ir_wr;
  logic             reg_wr;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [1:0]       ext_op;
  logic             mem_wr;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal;

  modport master (
    input  op, funct, alu_zero, dm_ready,
    output pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel, alu_src,
           alu_op, ext_op, mem_wr, state, instr_cnt, illegal
  );

  modport slave (
    output op, funct, alu_zero, dm_ready,
    input  pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel, alu_src,
           alu_op, ext_op, mem_wr, state, instr_cnt, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control unit (FETCH/DCD/EXE/MEM/WB)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mc_ctrl_if.master: op/funct/alu_zero/dm_ready in, datapath
//          strobes and selects, debug state, retired count, illegal out
// Optional feature: define MEM_WAIT_EN to stretch MEM until dm_ready=1.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mc_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Instruction decode
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
  logic is_beq, is_lui, is_j, is_jal, is_legal;

  assign is_r     = (bus.op == 6'h00);
  assign is_addu  = is_r && (bus.funct == 6'h21);
  assign is_subu  = is_r && (bus.funct == 6'h23);
  assign is_jr    = is_r && (bus.funct == 6'h08);
  assign is_ori   = (bus.op == 6'h0D);
  assign is_lw    = (bus.op == 6'h23);
  assign is_sw    = (bus.op == 6'h2B);
  assign is_beq   = (bus.op == 6'h04);
  assign is_lui   = (bus.op == 6'h0F);
  assign is_j     = (bus.op == 6'h02);
  assign is_jal   = (bus.op == 6'h03);
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                    is_beq | is_lui | is_j | is_jal;

  // ALU/extender selects for the non-branch EXE instructions; these are
  // held unchanged through MEM and WB so the datapath result stays stable.
  logic       hold_alu_src;
  logic [1:0] hold_alu_op;
  logic [1:0] hold_ext_op;

  assign hold_alu_src = is_ori | is_lui | is_lw | is_sw;
  assign hold_ext_op  = is_lui ? 2'b10 : ((is_lw | is_sw) ? 2'b01 : 2'b00);
  assign hold_alu_op  = is_subu ? 2'b01 : ((is_ori | is_lui) ? 2'b10 : 2'b00);

  logic       pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, illegal_c;
  logic [1:0] npc_sel_c, reg_dst_c, wd_sel_c, alu_op_c, ext_op_c;
  logic       alu_src_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_wr_c   = 1'b0;
    npc_sel_c = 2'b00;
    ir_wr_c   = 1'b0;
    reg_wr_c  = 1'b0;
    reg_dst_c = 2'b00;
    wd_sel_c  = 2'b00;
    alu_src_c = 1'b0;
    alu_op_c  = 2'b00;
    ext_op_c  = 2'b00;
    mem_wr_c  = 1'b0;
    illegal_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_wr_c = 1'b1;
        pc_wr_c = 1'b1;
        state_d = S_DCD;
      end

      S_DCD: begin
        if (is_j) begin
          pc_wr_c   = 1'b1;
          npc_sel_c = 2'b10;
        end else if (is_jal) begin
          pc_wr_c   = 1'b1;
          npc_sel_c = 2'b10;
          reg_wr_c  = 1'b1;
          reg_dst_c = 2'b10;
          wd_sel_c  = 2'b10;
        end else if (is_jr) begin
          pc_wr_c   = 1'b1;
          npc_sel_c = 2'b11;
        end else if (!is_legal) begin
          // Retired as a NOP: no datapath writes, just report it.
          illegal_c = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        if (is_beq) begin
          alu_op_c  = 2'b01;
          ext_op_c  = 2'b01;
          npc_sel_c = 2'b01;
          pc_wr_c   = bus.alu_zero;
        end else begin
          alu_src_c = hold_alu_src;
          alu_op_c  = hold_alu_op;
          ext_op_c  = hold_ext_op;
          if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else if (is_addu || is_subu || is_ori || is_lui) begin
            state_d = S_WB;
          end
        end
      end

      S_MEM: begin
        alu_src_c = hold_alu_src;
        alu_op_c  = hold_alu_op;
        ext_op_c  = hold_ext_op;
        mem_wr_c  = is_sw;
        state_d   = is_lw ? S_WB : S_FETCH;
`ifdef MEM_WAIT_EN
        if (!bus.dm_ready) begin
          state_d = S_MEM;
        end
`endif
      end

      S_WB: begin
        alu_src_c = hold_alu_src;
        alu_op_c  = hold_alu_op;
        ext_op_c  = hold_ext_op;
        reg_wr_c  = 1'b1;
        reg_dst_c = is_r ? 2'b01 : 2'b00;
        wd_sel_c  = is_lw ? 2'b01 : 2'b00;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Every arrival in FETCH retires one instruction (FETCH never loops to
  // itself, so this cannot double count).
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (state_d == S_FETCH) begin
      instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifndef MEM_WAIT_EN
  logic unused_dm_ready;
  assign unused_dm_ready = bus.dm_ready;
`endif

  // Strobes are gated with rst_n so nothing writes while reset is low,
  // even though state_q already sits in FETCH.
  assign bus.pc_wr     = pc_wr_c   & rst_n;
  assign bus.ir_wr     = ir_wr_c   & rst_n;
  assign bus.reg_wr    = reg_wr_c  & rst_n;
  assign bus.mem_wr    = mem_wr_c  & rst_n;
  assign bus.illegal   = illegal_c & rst_n;
  assign bus.npc_sel   = npc_sel_c;
  assign bus.reg_dst   = reg_dst_c;
  assign bus.wd_sel    = wd_sel_c;
  assign bus.alu_src   = alu_src_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.ext_op    = ext_op_c;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;

  localparam int CNT_W = 32;
`ifdef MEM_WAIT_EN
  localparam bit MEM_WAIT = 1'b1;
`else
  localparam bit MEM_WAIT = 1'b0;
`endif

  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4;
  localparam int C_SW = 5, C_BEQ = 6, C_LUI = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_wr;
    logic [2:0] state;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         len;
    int         n_pc;
    int         n_reg;
    int         n_mem;
    int         n_ill;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t actual();
    out_t o;
    o.pc_wr   = bus.pc_wr;
    o.npc_sel = bus.npc_sel;
    o.ir_wr   = bus.ir_wr;
    o.reg_wr  = bus.reg_wr;
    o.reg_dst = bus.reg_dst;
    o.wd_sel  = bus.wd_sel;
    o.alu_src = bus.alu_src;
    o.alu_op  = bus.alu_op;
    o.ext_op  = bus.ext_op;
    o.mem_wr  = bus.mem_wr;
    o.state   = bus.state;
    o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      6'h00: begin
        case (funct)
          6'h21:   return C_ADDU;
          6'h23:   return C_SUBU;
          6'h08:   return C_JR;
          default: return C_ILL;
        endcase
      end
      6'h0D:   return C_ORI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h0F:   return C_LUI;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // Expected outputs for one phase (state code) of an instruction class.
  function automatic out_t model(input int phase, input int cls, input logic zero);
    out_t o;
    o = '0;
    o.state = 3'(phase);
    if (phase == 0) begin
      o.ir_wr = 1'b1;
      o.pc_wr = 1'b1;
    end else if (phase == 1) begin
      if (cls == C_J) begin
        o.pc_wr = 1'b1; o.npc_sel = 2'b10;
      end else if (cls == C_JAL) begin
        o.pc_wr = 1'b1; o.npc_sel = 2'b10; o.reg_wr = 1'b1;
        o.reg_dst = 2'b10; o.wd_sel = 2'b10;
      end else if (cls == C_JR) begin
        o.pc_wr = 1'b1; o.npc_sel = 2'b11;
      end else if (cls == C_ILL) begin
        o.illegal = 1'b1;
      end
    end else begin
      if (cls == C_BEQ) begin
        o.alu_op = 2'b01; o.ext_op = 2'b01; o.npc_sel = 2'b01; o.pc_wr = zero;
      end else begin
        if (cls == C_SUBU) o.alu_op = 2'b01;
        if (cls == C_ORI) begin o.alu_src = 1'b1; o.alu_op = 2'b10; end
        if (cls == C_LUI) begin o.alu_src = 1'b1; o.alu_op = 2'b10; o.ext_op = 2'b10; end
        if (cls == C_LW || cls == C_SW) begin o.alu_src = 1'b1; o.ext_op = 2'b01; end
      end
      if (phase == 3 && cls == C_SW) o.mem_wr = 1'b1;
      if (phase == 4) begin
        o.reg_wr  = 1'b1;
        o.reg_dst = (cls == C_ADDU || cls == C_SUBU) ? 2'b01 : 2'b00;
        o.wd_sel  = (cls == C_LW) ? 2'b01 : 2'b00;
      end
    end
    return o;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; ends at the
  // negedge of the following FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                           input logic zero, input bit rnd_ready,
                           output int len, output int n_pc, output int n_reg,
                           output int n_mem, output int n_ill);
    int   seq[$];
    int   cls;
    int   stay;
    bit   waited;
    logic rdy;
    out_t a;
    cls = classify(op, funct);
    case (cls)
      C_J, C_JAL, C_JR, C_ILL: seq = '{0, 1};
      C_BEQ:                   seq = '{0, 1, 2};
      C_SW:                    seq = '{0, 1, 2, 3};
      C_LW:                    seq = '{0, 1, 2, 3, 4};
      default:                 seq = '{0, 1, 2, 4};
    endcase
    len = 0; n_pc = 0; n_reg = 0; n_mem = 0; n_ill = 0;
    bus.op = op;
    bus.funct = funct;
    bus.alu_zero = zero;
    for (int i = 0; i < seq.size(); i++) begin
      stay = 0;
      do begin
        bus.dm_ready = rnd_ready ? 1'($urandom) : 1'b1;
        #1;
        a = actual();
        chk($sformatf("cycle op=%h funct=%h phase=%0d", op, funct, seq[i]),
            64'(a), 64'(model(seq[i], cls, zero)));
        len++;
        n_pc  += int'(a.pc_wr);
        n_reg += int'(a.reg_wr);
        n_mem += int'(a.mem_wr);
        n_ill += int'(a.illegal);
        rdy = bus.dm_ready;
        @(posedge clk);
        @(negedge clk);
        waited = (seq[i] == 3) && MEM_WAIT && !rdy;
        stay++;
      end while (waited && stay < 40);
      if (waited) chk("mem_wait_bound", 64'(stay), 64'(0));
    end
    exp_cnt++;
    chk($sformatf("instr_cnt after op=%h", op), 64'(bus.instr_cnt), 64'(exp_cnt));
  endtask

  vec_t vecs[$];
  int   len, n_pc, n_reg, n_mem, n_ill;
  logic [5:0] rop, rfn;

  initial begin
    vecs.push_back('{6'h00, 6'h21, 1'b0, 4, 1, 1, 0, 0});  // addu
    vecs.push_back('{6'h23, 6'h00, 1'b0, 5, 1, 1, 0, 0});  // lw
    vecs.push_back('{6'h2B, 6'h00, 1'b0, 4, 1, 0, 1, 0});  // sw
    vecs.push_back('{6'h04, 6'h00, 1'b1, 3, 2, 0, 0, 0});  // beq taken
    vecs.push_back('{6'h04, 6'h00, 1'b0, 3, 1, 0, 0, 0});  // beq not taken
    vecs.push_back('{6'h03, 6'h00, 1'b0, 2, 2, 1, 0, 0});  // jal
    vecs.push_back('{6'h02, 6'h00, 1'b0, 2, 2, 0, 0, 0});  // j
    vecs.push_back('{6'h00, 6'h08, 1'b0, 2, 2, 0, 0, 0});  // jr
    vecs.push_back('{6'h0D, 6'h00, 1'b0, 4, 1, 1, 0, 0});  // ori
    vecs.push_back('{6'h0F, 6'h00, 1'b0, 4, 1, 1, 0, 0});  // lui
    vecs.push_back('{6'h3F, 6'h00, 1'b0, 2, 1, 0, 0, 1});  // illegal op
    vecs.push_back('{6'h00, 6'h23, 1'b0, 4, 1, 1, 0, 0});  // subu
    vecs.push_back('{6'h00, 6'h3F, 1'b0, 2, 1, 0, 0, 1});  // illegal funct

    bus.op = 6'h00; bus.funct = 6'h21; bus.alu_zero = 1'b0; bus.dm_ready = 1'b1;

    // Reset held three cycles: FETCH, counter clear, all strobes forced low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset state", 64'(bus.state), 64'(0));
      chk("reset strobes", 64'({bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_wr, bus.illegal}), 64'(0));
      chk("reset instr_cnt", 64'(bus.instr_cnt), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[k]) begin
      run_instr(vecs[k].op, vecs[k].funct, vecs[k].zero, 1'b0, len, n_pc, n_reg, n_mem, n_ill);
      chk($sformatf("vec%0d len", k), 64'(len), 64'(vecs[k].len));
      chk($sformatf("vec%0d pc_wr cycles", k), 64'(n_pc), 64'(vecs[k].n_pc));
      chk($sformatf("vec%0d reg_wr cycles", k), 64'(n_reg), 64'(vecs[k].n_reg));
      chk($sformatf("vec%0d mem_wr cycles", k), 64'(n_mem), 64'(vecs[k].n_mem));
      chk($sformatf("vec%0d illegal cycles", k), 64'(n_ill), 64'(vecs[k].n_ill));
    end

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 11))
        0: begin rop = 6'h00; rfn = 6'h21; end
        1: begin rop = 6'h00; rfn = 6'h23; end
        2: begin rop = 6'h00; rfn = 6'h08; end
        3: begin rop = 6'h0D; rfn = 6'($urandom); end
        4: begin rop = 6'h23; rfn = 6'($urandom); end
        5: begin rop = 6'h2B; rfn = 6'($urandom); end
        6: begin rop = 6'h04; rfn = 6'($urandom); end
        7: begin rop = 6'h0F; rfn = 6'($urandom); end
        8: begin rop = 6'h02; rfn = 6'($urandom); end
        9: begin rop = 6'h03; rfn = 6'($urandom); end
        10: begin rop = 6'h00; rfn = 6'($urandom); end
        default: begin rop = 6'($urandom); rfn = 6'($urandom); end
      endcase
      run_instr(rop, rfn, 1'($urandom), 1'b1, len, n_pc, n_reg, n_mem, n_ill);
    end

    // Reset in the middle of lw (EXE): back to FETCH at once, counter clears.
    bus.op = 6'h23; bus.funct = 6'h00; bus.dm_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lw reached EXE", 64'(bus.state), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("mid reset state", 64'(bus.state), 64'(0));
    chk("mid reset strobes", 64'({bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_wr, bus.illegal}), 64'(0));
    chk("mid reset instr_cnt", 64'(bus.instr_cnt), 64'(0));
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'h00, 6'h21, 1'b0, 1'b0, len, n_pc, n_reg, n_mem, n_ill);

`ifdef MEM_WAIT_EN
    // sw with dm_ready low for four MEM cycles: mem_wr held five cycles.
    begin
      int mem_cycles;
      int wr_cycles;
      int guard;
      bit left_fetch;
      mem_cycles = 0; wr_cycles = 0; guard = 0; left_fetch = 1'b0;
      bus.op = 6'h2B; bus.funct = 6'h00; bus.dm_ready = 1'b0;
      while (guard < 30 && !(left_fetch && bus.state == 3'd0)) begin
        if (bus.state != 3'd0) left_fetch = 1'b1;
        if (bus.state == 3'd3) begin
          mem_cycles++;
          bus.dm_ready = (mem_cycles >= 5);
        end
        #1;
        wr_cycles += int'(bus.mem_wr);
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      chk("sw wait bound", 64'(guard < 30), 64'(1));
      chk("sw wait mem_wr cycles", 64'(wr_cycles), 64'(5));
      chk("sw wait MEM cycles", 64'(mem_cycles), 64'(5));
      exp_cnt++;
      chk("sw wait instr_cnt", 64'(bus.instr_cnt), 64'(exp_cnt));

      // Reset during the wait aborts to FETCH with mem_wr low.
      bus.dm_ready = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("sw in wait", 64'({bus.state, bus.mem_wr}), 64'({3'd3, 1'b1}));
      rst_n = 1'b0;
      #1;
      chk("wait reset state", 64'(bus.state), 64'(0));
      chk("wait reset mem_wr", 64'(bus.mem_wr), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.dm_ready = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
